// File: rtl/id_ex_stage.sv
// ID/EX register for the two-slot VLIW core. It inserts one bubble on an S-slot load-use hazard and honours flush and mem_busy. Optional bubble counter: ID_EX_STALL_CNT_EN.
// Latency is 1 cycle from IF/ID to ID_EX*. stall is combinational, and mem_busy freezes every stage register.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  IF_IDRm,
  input  logic [REG_W-1:0]  IF_IDRn,
  input  logic [REG_W-1:0]  IF_IDRd,
  input  logic [REG_W-1:0]  IF_IDSm,
  input  logic [REG_W-1:0]  IF_IDSn,
  input  logic [REG_W-1:0]  IF_IDSd,
  input  logic [DATA_W-1:0] IF_IDRmVal,
  input  logic [DATA_W-1:0] IF_IDRnVal,
  input  logic [DATA_W-1:0] IF_IDSmVal,
  input  logic [DATA_W-1:0] IF_IDSnVal,
  input  logic [DATA_W-1:0] IF_IDSdVal,
  input  logic              IF_IDRRegWrite,
  input  logic              IF_IDSRegWrite,
  input  logic              IF_IDMR,
  input  logic              IF_IDMW,
  input  logic              flush,
  input  logic              mem_busy,
  output logic [REG_W-1:0]  ID_EXRm,
  output logic [REG_W-1:0]  ID_EXRn,
  output logic [REG_W-1:0]  ID_EXRd,
  output logic [REG_W-1:0]  ID_EXSm,
  output logic [REG_W-1:0]  ID_EXSn,
  output logic [REG_W-1:0]  ID_EXSd,
  output logic [DATA_W-1:0] ID_EXRmVal,
  output logic [DATA_W-1:0] ID_EXRnVal,
  output logic [DATA_W-1:0] ID_EXSmVal,
  output logic [DATA_W-1:0] ID_EXSnVal,
  output logic [DATA_W-1:0] ID_EXSdVal,
  output logic              ID_EXRRegWrite,
  output logic              ID_EXSRegWrite,
  output logic              ID_EXMR,
  output logic              ID_EXMW,
  output logic              ID_EXValid,
  output logic              stall,
  output logic [15:0]       stall_count
);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0]  rm;
    logic [REG_W-1:0]  rn;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  sm;
    logic [REG_W-1:0]  sn;
    logic [REG_W-1:0]  sd;
    logic [DATA_W-1:0] rm_val;
    logic [DATA_W-1:0] rn_val;
    logic [DATA_W-1:0] sm_val;
    logic [DATA_W-1:0] sn_val;
    logic [DATA_W-1:0] sd_val;
    logic              r_reg_write;
    logic              s_reg_write;
    logic              mr;
    logic              mw;
    logic              valid;
  } ex_t;

  state_t state_q, state_d;
  ex_t    ex_q, ex_d;
  ex_t    if_id;
  logic   lu;

  always_comb begin
    if_id             = '0;
    if_id.rm          = IF_IDRm;
    if_id.rn          = IF_IDRn;
    if_id.rd          = IF_IDRd;
    if_id.sm          = IF_IDSm;
    if_id.sn          = IF_IDSn;
    if_id.sd          = IF_IDSd;
    if_id.rm_val      = IF_IDRmVal;
    if_id.rn_val      = IF_IDRnVal;
    if_id.sm_val      = IF_IDSmVal;
    if_id.sn_val      = IF_IDSnVal;
    if_id.sd_val      = IF_IDSdVal;
    if_id.r_reg_write = IF_IDRRegWrite;
    if_id.s_reg_write = IF_IDSRegWrite;
    if_id.mr          = IF_IDMR;
    if_id.mw          = IF_IDMW;
    if_id.valid       = 1'b1;
  end

  // The store-data read (IF_IDSd) is left out on purpose: the load-store forward path covers it.
  always_comb begin
    lu = ex_q.mr && (ex_q.sd != '0) &&
         ((ex_q.sd == IF_IDRm) || (ex_q.sd == IF_IDRn) ||
          (ex_q.sd == IF_IDSm) || (ex_q.sd == IF_IDSn));
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
`endif

  always_comb begin
    ex_d    = ex_q;
    state_d = state_q;
    stall   = 1'b0;
`ifdef ID_EX_STALL_CNT_EN
    stall_cnt_d = stall_cnt_q;
`endif
    if (mem_busy) begin
      stall = 1'b1;
    end else if (flush) begin
      ex_d    = '0;
      state_d = RUN;
    end else if (lu && (state_q == RUN)) begin
      ex_d    = '0;
      stall   = 1'b1;
      state_d = BUBBLE;
`ifdef ID_EX_STALL_CNT_EN
      if (stall_cnt_q != 16'hFFFF) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
`endif
    end else begin
      ex_d    = if_id;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ex_q    <= '0;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'd0;
`endif

  // The bubble carries MR=0, so a hazard seen while in BUBBLE means the stage logic is broken.
  assert property (@(posedge clk) disable iff (rst) !((state_q == BUBBLE) && lu));

  assign ID_EXRm        = ex_q.rm;
  assign ID_EXRn        = ex_q.rn;
  assign ID_EXRd        = ex_q.rd;
  assign ID_EXSm        = ex_q.sm;
  assign ID_EXSn        = ex_q.sn;
  assign ID_EXSd        = ex_q.sd;
  assign ID_EXRmVal     = ex_q.rm_val;
  assign ID_EXRnVal     = ex_q.rn_val;
  assign ID_EXSmVal     = ex_q.sm_val;
  assign ID_EXSnVal     = ex_q.sn_val;
  assign ID_EXSdVal     = ex_q.sd_val;
  assign ID_EXRRegWrite = ex_q.r_reg_write;
  assign ID_EXSRegWrite = ex_q.s_reg_write;
  assign ID_EXMR        = ex_q.mr;
  assign ID_EXMW        = ex_q.mw;
  assign ID_EXValid     = ex_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized bench for id_ex_stage. A behavioural model of the ID/EX contents is checked every cycle, and directed scenarios add literal expectations.
module tb_id_ex_stage;
  localparam int DW = 16;
  localparam int RW = 3;
`ifdef ID_EX_STALL_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [RW-1:0] IF_IDRm, IF_IDRn, IF_IDRd, IF_IDSm, IF_IDSn, IF_IDSd;
  logic [DW-1:0] IF_IDRmVal, IF_IDRnVal, IF_IDSmVal, IF_IDSnVal, IF_IDSdVal;
  logic          IF_IDRRegWrite, IF_IDSRegWrite, IF_IDMR, IF_IDMW, flush, mem_busy;
  logic [RW-1:0] ID_EXRm, ID_EXRn, ID_EXRd, ID_EXSm, ID_EXSn, ID_EXSd;
  logic [DW-1:0] ID_EXRmVal, ID_EXRnVal, ID_EXSmVal, ID_EXSnVal, ID_EXSdVal;
  logic          ID_EXRRegWrite, ID_EXSRegWrite, ID_EXMR, ID_EXMW, ID_EXValid, stall;
  logic [15:0]   stall_count;

  id_ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (
    .clk(clk), .rst(rst),
    .IF_IDRm(IF_IDRm), .IF_IDRn(IF_IDRn), .IF_IDRd(IF_IDRd),
    .IF_IDSm(IF_IDSm), .IF_IDSn(IF_IDSn), .IF_IDSd(IF_IDSd),
    .IF_IDRmVal(IF_IDRmVal), .IF_IDRnVal(IF_IDRnVal), .IF_IDSmVal(IF_IDSmVal),
    .IF_IDSnVal(IF_IDSnVal), .IF_IDSdVal(IF_IDSdVal),
    .IF_IDRRegWrite(IF_IDRRegWrite), .IF_IDSRegWrite(IF_IDSRegWrite),
    .IF_IDMR(IF_IDMR), .IF_IDMW(IF_IDMW), .flush(flush), .mem_busy(mem_busy),
    .ID_EXRm(ID_EXRm), .ID_EXRn(ID_EXRn), .ID_EXRd(ID_EXRd),
    .ID_EXSm(ID_EXSm), .ID_EXSn(ID_EXSn), .ID_EXSd(ID_EXSd),
    .ID_EXRmVal(ID_EXRmVal), .ID_EXRnVal(ID_EXRnVal), .ID_EXSmVal(ID_EXSmVal),
    .ID_EXSnVal(ID_EXSnVal), .ID_EXSdVal(ID_EXSdVal),
    .ID_EXRRegWrite(ID_EXRRegWrite), .ID_EXSRegWrite(ID_EXSRegWrite),
    .ID_EXMR(ID_EXMR), .ID_EXMW(ID_EXMW), .ID_EXValid(ID_EXValid),
    .stall(stall), .stall_count(stall_count)
  );

  // Model contents of the ID/EX register: one entry per instruction slot pair.
  typedef struct {
    logic [RW-1:0] rm, rn, rd, sm, sn, sd;
    logic [DW-1:0] rmv, rnv, smv, snv, sdv;
    logic          rrw, srw, mr, mw, valid;
  } ent_t;

  ent_t exp_e;
  int   exp_cnt;
  bit   known;
  int   n_chk;
  int   n_pass;

  function automatic ent_t bubble_ent();
    ent_t e;
    e.rm = 0; e.rn = 0; e.rd = 0; e.sm = 0; e.sn = 0; e.sd = 0;
    e.rmv = 0; e.rnv = 0; e.smv = 0; e.snv = 0; e.sdv = 0;
    e.rrw = 0; e.srw = 0; e.mr = 0; e.mw = 0; e.valid = 0;
    return e;
  endfunction

  function automatic ent_t input_ent();
    ent_t e;
    e.rm = IF_IDRm; e.rn = IF_IDRn; e.rd = IF_IDRd;
    e.sm = IF_IDSm; e.sn = IF_IDSn; e.sd = IF_IDSd;
    e.rmv = IF_IDRmVal; e.rnv = IF_IDRnVal; e.smv = IF_IDSmVal;
    e.snv = IF_IDSnVal; e.sdv = IF_IDSdVal;
    e.rrw = IF_IDRRegWrite; e.srw = IF_IDSRegWrite;
    e.mr = IF_IDMR; e.mw = IF_IDMW; e.valid = 1'b1;
    return e;
  endfunction

  function automatic bit model_lu();
    bit hit;
    hit = (exp_e.sd == IF_IDRm) || (exp_e.sd == IF_IDRn) ||
          (exp_e.sd == IF_IDSm) || (exp_e.sd == IF_IDSn);
    return exp_e.mr && (exp_e.sd != 0) && hit;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
  endtask

  task automatic compare();
    logic exp_stall;
    exp_stall = mem_busy || (!flush && model_lu());
    chk("rm", 32'(ID_EXRm), 32'(exp_e.rm));
    chk("rn", 32'(ID_EXRn), 32'(exp_e.rn));
    chk("rd", 32'(ID_EXRd), 32'(exp_e.rd));
    chk("sm", 32'(ID_EXSm), 32'(exp_e.sm));
    chk("sn", 32'(ID_EXSn), 32'(exp_e.sn));
    chk("sd", 32'(ID_EXSd), 32'(exp_e.sd));
    chk("rm_val", 32'(ID_EXRmVal), 32'(exp_e.rmv));
    chk("rn_val", 32'(ID_EXRnVal), 32'(exp_e.rnv));
    chk("sm_val", 32'(ID_EXSmVal), 32'(exp_e.smv));
    chk("sn_val", 32'(ID_EXSnVal), 32'(exp_e.snv));
    chk("sd_val", 32'(ID_EXSdVal), 32'(exp_e.sdv));
    chk("r_regwrite", 32'(ID_EXRRegWrite), 32'(exp_e.rrw));
    chk("s_regwrite", 32'(ID_EXSRegWrite), 32'(exp_e.srw));
    chk("mr", 32'(ID_EXMR), 32'(exp_e.mr));
    chk("mw", 32'(ID_EXMW), 32'(exp_e.mw));
    chk("valid", 32'(ID_EXValid), 32'(exp_e.valid));
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("stall_count", 32'(stall_count), CNT_ON ? 32'(exp_cnt) : 32'd0);
  endtask

  // One clock: sample and compare mid-cycle, then advance the model across the edge.
  task automatic step(output logic st);
    ent_t nxt;
    int   ncnt;
    #3;
    st = stall;
    if (known) compare();
    nxt  = exp_e;
    ncnt = exp_cnt;
    if (rst) begin
      nxt  = bubble_ent();
      ncnt = 0;
    end else if (mem_busy) begin
      nxt = exp_e;
    end else if (flush) begin
      nxt = bubble_ent();
    end else if (model_lu()) begin
      nxt = bubble_ent();
      if (ncnt < 65535) ncnt++;
    end else begin
      nxt = input_ent();
    end
    @(posedge clk);
    #1;
    exp_e   = nxt;
    exp_cnt = ncnt;
    known   = 1'b1;
  endtask

  task automatic clear_in();
    rst = 0; flush = 0; mem_busy = 0;
    IF_IDRm = 0; IF_IDRn = 0; IF_IDRd = 0; IF_IDSm = 0; IF_IDSn = 0; IF_IDSd = 0;
    IF_IDRmVal = 0; IF_IDRnVal = 0; IF_IDSmVal = 0; IF_IDSnVal = 0; IF_IDSdVal = 0;
    IF_IDRRegWrite = 0; IF_IDSRegWrite = 0; IF_IDMR = 0; IF_IDMW = 0;
  endtask

  task automatic rand_in();
    IF_IDRm = 3'($urandom_range(0, 7)); IF_IDRn = 3'($urandom_range(0, 7));
    IF_IDRd = 3'($urandom_range(0, 7)); IF_IDSm = 3'($urandom_range(0, 7));
    IF_IDSn = 3'($urandom_range(0, 7)); IF_IDSd = 3'($urandom_range(0, 7));
    IF_IDRmVal = 16'($urandom); IF_IDRnVal = 16'($urandom); IF_IDSmVal = 16'($urandom);
    IF_IDSnVal = 16'($urandom); IF_IDSdVal = 16'($urandom);
    IF_IDRRegWrite = 1'($urandom_range(0, 1)); IF_IDSRegWrite = 1'($urandom_range(0, 1));
    IF_IDMR  = ($urandom_range(0, 9) < 4);
    IF_IDMW  = !IF_IDMR && ($urandom_range(0, 3) == 0);
    flush    = ($urandom_range(0, 19) == 0);
    mem_busy = ($urandom_range(0, 9) == 0);
    rst      = ($urandom_range(0, 99) == 0);
  endtask

  task automatic do_reset();
    clear_in();
    rst = 1;
    IF_IDRm = 3; IF_IDSd = 5; IF_IDRmVal = 16'hA5A5; IF_IDMR = 1; IF_IDRRegWrite = 1;
  endtask

  initial begin
    logic st;
    n_chk = 0; n_pass = 0; known = 0; exp_cnt = 0;
    exp_e = bubble_ent();

    // Reset for 2 cycles with nonzero inputs.
    do_reset();
    step(st);
    step(st);
    clear_in();
    chk("rst_valid", 32'(ID_EXValid), 32'd0);
    chk("rst_rm", 32'(ID_EXRm), 32'd0);
    chk("rst_sd", 32'(ID_EXSd), 32'd0);
    chk("rst_rmval", 32'(ID_EXRmVal), 32'd0);
    chk("rst_mr", 32'(ID_EXMR), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_count", 32'(stall_count), 32'd0);

    // Load r3, then a consumer reading r3 in the R slot.
    clear_in(); IF_IDSd = 3; IF_IDMR = 1; IF_IDSRegWrite = 1;
    step(st);
    chk("lu_load_nostall", 32'(st), 32'd0);
    clear_in(); IF_IDRm = 3; IF_IDRmVal = 16'h1234; IF_IDRRegWrite = 1;
    step(st);
    chk("lu_stall", 32'(st), 32'd1);
    chk("lu_bubble_valid", 32'(ID_EXValid), 32'd0);
    step(st);
    chk("lu_stall_one_cycle", 32'(st), 32'd0);
    chk("lu_consumer_valid", 32'(ID_EXValid), 32'd1);
    chk("lu_consumer_rm", 32'(ID_EXRm), 32'd3);
    chk("lu_consumer_rmval", 32'(ID_EXRmVal), 32'h1234);
    chk("lu_count", 32'(stall_count), CNT_ON ? 32'd1 : 32'd0);

    // A load to r0 followed by a reader of r0 must not stall.
    clear_in(); IF_IDSd = 0; IF_IDMR = 1;
    step(st);
    clear_in(); IF_IDRm = 0; IF_IDSn = 0;
    step(st);
    chk("r0_nostall", 32'(st), 32'd0);
    chk("r0_captured", 32'(ID_EXValid), 32'd1);

    // A load to r5 followed by a store whose data register is r5 must not stall.
    clear_in(); IF_IDSd = 5; IF_IDMR = 1;
    step(st);
    clear_in(); IF_IDSd = 5; IF_IDMW = 1; IF_IDSm = 1; IF_IDSn = 2;
    step(st);
    chk("st_data_nostall", 32'(st), 32'd0);
    chk("st_data_mw", 32'(ID_EXMW), 32'd1);

    // A hazard coinciding with flush gives a flush bubble, with no stall and no count.
    clear_in(); IF_IDSd = 3; IF_IDMR = 1;
    step(st);
    clear_in(); IF_IDRm = 3; flush = 1;
    step(st);
    chk("flush_lu_stall", 32'(st), 32'd0);
    chk("flush_lu_valid", 32'(ID_EXValid), 32'd0);
    chk("flush_lu_count", 32'(stall_count), CNT_ON ? 32'd1 : 32'd0);

    // Freeze for 3 cycles with changing inputs and a flush pulse.
    clear_in(); IF_IDRm = 2; IF_IDRmVal = 16'hBEEF;
    step(st);
    for (int i = 0; i < 3; i++) begin
      mem_busy = 1; flush = (i == 1);
      IF_IDRm = 3'(i + 4); IF_IDRmVal = 16'($urandom);
      step(st);
      chk("frz_stall", 32'(st), 32'd1);
      chk("frz_rm", 32'(ID_EXRm), 32'd2);
      chk("frz_rmval", 32'(ID_EXRmVal), 32'hBEEF);
    end
    clear_in(); IF_IDRm = 6; IF_IDRmVal = 16'h0777;
    step(st);
    chk("frz_resume_rm", 32'(ID_EXRm), 32'd6);
    chk("frz_resume_val", 32'(ID_EXRmVal), 32'h0777);
    chk("frz_resume_valid", 32'(ID_EXValid), 32'd1);

    // Reset arriving during a load-use stall.
    clear_in(); IF_IDSd = 4; IF_IDMR = 1;
    step(st);
    clear_in(); IF_IDSn = 4; rst = 1;
    step(st);
    chk("rst_mid_stall_seen", 32'(st), 32'd1);
    chk("rst_mid_valid", 32'(ID_EXValid), 32'd0);
    chk("rst_mid_count", 32'(stall_count), 32'd0);
    clear_in();
    step(st);
    chk("rst_mid_after_stall", 32'(st), 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      step(st);
    end

`ifdef ID_EX_STALL_CNT_EN
    // Back-to-back dependent loads: every other cycle is a load-use bubble.
    clear_in(); rst = 1;
    step(st);
    clear_in(); IF_IDSd = 1; IF_IDRm = 1; IF_IDMR = 1;
    for (int i = 0; i < 140002; i++) step(st);
    chk("sat_count", 32'(stall_count), 32'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register for the two-slot VLIW core (R slot: ALU; S slot: ALU/memory). Captures decoded register specifiers, operand values and control bits from IF/ID and presents them as the `ID_EX*` fields consumed by the forwarding unit and the EX stage. Detects S-slot load-use hazards the forwarding network cannot cover, stalls fetch/decode and inserts one bubble. Also handles branch flush and memory-busy freeze.

## Interface
- `DATA_W`, default 16, width of register operand values.
- `REG_W`, default 3, width of register specifiers (r0 hardwired zero).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `IF_IDRm`, `IF_IDRn`, `IF_IDRd`, `IF_IDSm`, `IF_IDSn`, `IF_IDSd`  in  REG_W each  decoded specifiers, R and S slots.
- `IF_IDRmVal`, `IF_IDRnVal`, `IF_IDSmVal`, `IF_IDSnVal`, `IF_IDSdVal`  in  DATA_W each  register-file read data.
- `IF_IDRRegWrite`, `IF_IDSRegWrite`, `IF_IDMR`, `IF_IDMW`  in  1 each  decoded control (MR/MW: S-slot load/store).
- `flush`  in  1  branch taken in EX; squash the instruction in IF/ID.
- `mem_busy`  in  1  memory stage not ready; freeze the pipeline.
- `ID_EXRm`, `ID_EXRn`, `ID_EXRd`, `ID_EXSm`, `ID_EXSn`, `ID_EXSd`  out  REG_W each  registered specifiers.
- `ID_EXRmVal`, `ID_EXRnVal`, `ID_EXSmVal`, `ID_EXSnVal`, `ID_EXSdVal`  out  DATA_W each  registered operands.
- `ID_EXRRegWrite`, `ID_EXSRegWrite`, `ID_EXMR`, `ID_EXMW`  out  1 each  registered control.
- `ID_EXValid`  out  1  1 = real instruction, 0 = bubble.
- `stall`  out  1  combinational; PC and IF/ID must hold this cycle.
- `stall_count`  out  16  bubble counter (only with `ID_EX_STALL_CNT_EN`, else tied 0).

## Operation
- Bubble: all specifiers, values and control bits 0, `ID_EXValid`=0. Reset loads a bubble; FSM to RUN; `stall`=0.
- Load-use hazard `lu` = `ID_EXMR` & `ID_EXSd`!=0 & `ID_EXSd` equals any of `IF_IDRm`, `IF_IDRn`, `IF_IDSm`, `IF_IDSn`. `IF_IDSd` excluded: load→store-data is covered by the load-store forward path.
- Priority per cycle, highest first:
  - `mem_busy`: all ID/EX registers hold; `stall`=1; `flush` and `lu` ignored; FSM holds.
  - `flush`: load bubble; `stall`=0; FSM to RUN.
  - `lu` in RUN: load bubble; `stall`=1; FSM to BUBBLE.
  - Otherwise capture IF/ID inputs, `ID_EXValid`=1; `stall`=0; FSM to RUN.
- FSM states RUN, BUBBLE. BUBBLE lasts exactly one cycle; `lu` is structurally false there because the ID/EX bubble has MR=0. If `lu` is seen in BUBBLE, it is a design error; assertion fires.
- Back-to-back loads into dependent consumers each get exactly one bubble.

## Timing
- Capture latency: 1 cycle, IF/ID inputs to `ID_EX*` outputs.
- `stall` is combinational from current ID/EX state, IF/ID specifiers, `flush` and `mem_busy`. No register on its path.
- Load-use costs exactly 1 bubble cycle. Consumer reaches EX 2 cycles after the load, where MEM/WB forwarding supplies the value.
- `flush` is a single-cycle pulse. If it coincides with `mem_busy`, the branch unit holds it until `mem_busy` deasserts.
- `rst` mid-stall: next edge yields bubble, RUN, `stall`=0, counter 0.

## Configuration
- `ID_EX_STALL_CNT_EN` defined: 16-bit counter increments on each edge where a load-use bubble is inserted. Saturates at 0xFFFF. Cleared by `rst`. Flush bubbles and `mem_busy` cycles are not counted.
- Undefined: no counter logic; `stall_count` is driven 0.

## Test plan
- Reset: assert `rst` 2 cycles with nonzero inputs. Required: all outputs 0, `ID_EXValid`=0, `stall`=0.
- Load-use: load with `IF_IDSd`=3, `IF_IDMR`=1; next instruction has `IF_IDRm`=3. Required: `stall`=1 for 1 cycle, one bubble in ID/EX, consumer captured the following cycle, `stall_count`=1.
- No stall on r0 or store data: load to r0 followed by reader of r0. Separately, load r5 followed by store with `IF_IDSd`=5. Required: `stall`=0 in both, no bubble.
- Flush vs hazard: `lu` true and `flush`=1 in the same cycle. Required: bubble loaded, `stall`=0, `stall_count` unchanged.
- Freeze: `mem_busy`=1 for 3 cycles with changing IF/ID inputs and a `flush` pulse. Required: `ID_EX*` outputs unchanged, `stall`=1 throughout. Normal capture resumes on the first edge after release.
- Saturation (macro on): force 70000 load-use bubbles. Required: `stall_count`=0xFFFF.
